// File: rtl/cordic_polar2rect.sv
// Iterative rotation-mode CORDIC: polar (Q18.14 magnitude, rad*2^28 phase) to
// rectangular Q18.14 (x, y), one micro-rotation per clock with start/busy/done.
module cordic_polar2rect #(
  parameter int unsigned INT_WIDTH      = 32,
  parameter int unsigned ITERATIONS     = 32,
  parameter int unsigned GAIN_FRAC_BITS = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [INT_WIDTH-1:0] magnitude,
  input  logic [INT_WIDTH-1:0] phase,
  output logic                 busy,
  output logic                 done,
  output logic [INT_WIDTH-1:0] x_out,
  output logic [INT_WIDTH-1:0] y_out
);

  localparam int unsigned DW = INT_WIDTH + 2;
  localparam int unsigned CW = $clog2(ITERATIONS + 1);
  localparam int unsigned PW = INT_WIDTH + GAIN_FRAC_BITS + 4;

  localparam logic signed [DW-1:0] PI_C     = DW'(843314856);
  localparam logic signed [DW-1:0] TWOPI_C  = DW'(1686629713);
  localparam logic signed [DW-1:0] HALFPI_C = DW'(421657428);
  localparam logic [PW-1:0]        K_INV    = PW'(163008218);
  localparam logic [INT_WIDTH-1:0] MAG_MAX  = {1'b0, {(INT_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESCALE,
    S_ITERATE,
    S_POST,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [INT_WIDTH-1:0]   mag_q, mag_d;
  logic signed [DW-1:0]   x_q, x_d;
  logic signed [DW-1:0]   y_q, y_d;
  logic signed [DW-1:0]   z_q, z_d;
  logic                   neg_q, neg_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [INT_WIDTH-1:0]   x_out_q, x_out_d;
  logic [INT_WIDTH-1:0]   y_out_q, y_out_d;

  logic signed [DW-1:0]   ph_ext;
  logic signed [DW-1:0]   ph_wrap;
  logic signed [DW-1:0]   z_fold;
  logic                   neg_fold;
  logic [INT_WIDTH-1:0]   mag_sat;
  logic [PW-1:0]          prod;
  logic signed [DW-1:0]   x_sh;
  logic signed [DW-1:0]   y_sh;
  logic signed [DW-1:0]   atan_i;

  // round(atan(2^-i) * 2^28); below i=10 the cubic term still matters, above it the entry is 2^(28-i)
  function automatic logic signed [DW-1:0] atan_lut(input logic [CW-1:0] idx);
    int unsigned v;
    v = 0;
    case (int'(idx))
      0:       v = 210828714;
      1:       v = 124459457;
      2:       v = 65760959;
      3:       v = 33381290;
      4:       v = 16755422;
      5:       v = 8385879;
      6:       v = 4193963;
      7:       v = 2097109;
      8:       v = 1048571;
      9:       v = 524287;
      default: begin
        if (int'(idx) <= 28) v = 32'd1 << (28 - int'(idx));
      end
    endcase
    return DW'(v);
  endfunction

  // Input conditioning: saturate magnitude, wrap phase once, fold into [-pi/2, pi/2]
  always_comb begin
    mag_sat = magnitude[INT_WIDTH-1] ? MAG_MAX : magnitude;
    ph_ext  = DW'($signed(phase));
    ph_wrap = ph_ext;
    if (ph_ext > PI_C) begin
      ph_wrap = ph_ext - TWOPI_C;
    end else if (ph_ext < -PI_C) begin
      ph_wrap = ph_ext + TWOPI_C;
    end
    z_fold   = ph_wrap;
    neg_fold = 1'b0;
    if (ph_wrap > HALFPI_C) begin
      z_fold   = ph_wrap - PI_C;
      neg_fold = 1'b1;
    end else if (ph_wrap < -HALFPI_C) begin
      z_fold   = ph_wrap + PI_C;
      neg_fold = 1'b1;
    end
  end

  assign prod   = PW'(mag_q) * K_INV;
  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign atan_i = atan_lut(cnt_q);

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRESCALE;
          mag_d   = mag_sat;
          z_d     = z_fold;
          neg_d   = neg_fold;
        end
      end
      S_PRESCALE: begin
        state_d = S_ITERATE;
        busy_d  = 1'b1;
        x_d     = DW'(prod >> GAIN_FRAC_BITS);
        y_d     = '0;
        cnt_d   = '0;
      end
      S_ITERATE: begin
        busy_d = 1'b1;
        if (!z_q[DW-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERATIONS - 1)) begin
          state_d = S_POST;
        end
      end
      S_POST: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        x_out_d = INT_WIDTH'(neg_q ? -x_q : x_q);
        y_out_d = INT_WIDTH'(neg_q ? -y_q : y_q);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_out_q <= '0;
      y_out_q <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign x_out = x_out_q;
  assign y_out = y_out_q;

endmodule
